// File: rtl/pin_entry.sv
// Keypad PIN collector/checker: gathers BCD digits, compares against the card's PIN, tracks retries and lockout.
// Registered outputs; pin_done lands two cycles after enter is sampled. No backpressure: keys are accepted or flagged via digit_err.
module pin_entry #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_in,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic                    clear,
  input  logic                    enter,
  input  logic                    unlock,
  input  logic [4*PIN_DIGITS-1:0] pin_expected,
  output logic [2:0]              digit_count,
  output logic                    pin_done,
  output logic                    wrong_psw,
  output logic                    pin_ok,
  output logic                    locked,
  output logic                    digit_err,
  output logic                    pin_timeout
);

  localparam int PW = 4 * PIN_DIGITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, GRANTED, LOCKED} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pin_buf, pin_buf_n;
  logic [CW-1:0] idle_cnt, idle_cnt_n;
  logic [FW-1:0] fail_cnt, fail_cnt_n;
  logic [2:0]    digit_count_n;
  logic          pin_done_n, wrong_psw_n, pin_ok_n, locked_n, digit_err_n, pin_timeout_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pin_buf     <= '0;
      idle_cnt    <= '0;
      fail_cnt    <= '0;
      digit_count <= '0;
      pin_done    <= 1'b0;
      wrong_psw   <= 1'b0;
      pin_ok      <= 1'b0;
      locked      <= 1'b0;
      digit_err   <= 1'b0;
      pin_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      pin_buf     <= pin_buf_n;
      idle_cnt    <= idle_cnt_n;
      fail_cnt    <= fail_cnt_n;
      digit_count <= digit_count_n;
      pin_done    <= pin_done_n;
      wrong_psw   <= wrong_psw_n;
      pin_ok      <= pin_ok_n;
      locked      <= locked_n;
      digit_err   <= digit_err_n;
      pin_timeout <= pin_timeout_n;
    end
  end

  always_comb begin
    state_n       = state;
    pin_buf_n     = pin_buf;
    idle_cnt_n    = idle_cnt;
    fail_cnt_n    = fail_cnt;
    digit_count_n = digit_count;
    pin_done_n    = 1'b0;
    wrong_psw_n   = wrong_psw;
    pin_ok_n      = pin_ok;
    locked_n      = locked;
    digit_err_n   = 1'b0;
    pin_timeout_n = 1'b0;

    if (unlock) locked_n = 1'b0;

    // Card removal overrides everything, including a simultaneous unlock.
    if (state != IDLE && !card_in) begin
      state_n       = IDLE;
      pin_buf_n     = '0;
      digit_count_n = '0;
      idle_cnt_n    = '0;
      fail_cnt_n    = '0;
      pin_ok_n      = 1'b0;
      wrong_psw_n   = 1'b0;
      locked_n      = locked;
    end else begin
      case (state)
        IDLE: begin
          if (card_in) begin
            if (locked_n) begin
              state_n = LOCKED;
            end else begin
              state_n       = COLLECT;
              pin_buf_n     = '0;
              digit_count_n = '0;
              idle_cnt_n    = '0;
            end
          end
        end
        COLLECT: begin
          if (clear) begin
            pin_buf_n     = '0;
            digit_count_n = '0;
            idle_cnt_n    = '0;
          end else if (enter) begin
            idle_cnt_n = '0;
            if (digit_count == 3'(PIN_DIGITS)) state_n = CHECK;
            else digit_err_n = 1'b1;
          end else if (digit_valid) begin
            idle_cnt_n = '0;
            if (digit <= 4'd9 && digit_count < 3'(PIN_DIGITS)) begin
              pin_buf_n     = (pin_buf << 4) | PW'(digit);
              digit_count_n = digit_count + 3'd1;
            end else begin
              digit_err_n = 1'b1;
            end
          end else if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_n       = IDLE;
            pin_timeout_n = 1'b1;
            pin_buf_n     = '0;
            digit_count_n = '0;
            idle_cnt_n    = '0;
            wrong_psw_n   = 1'b0;
          end else begin
            idle_cnt_n = idle_cnt + CW'(1);
          end
        end
        CHECK: begin
          pin_done_n = 1'b1;
          if (pin_buf == pin_expected) begin
            state_n     = GRANTED;
            wrong_psw_n = 1'b0;
            fail_cnt_n  = '0;
            pin_ok_n    = 1'b1;
          end else begin
            wrong_psw_n   = 1'b1;
            pin_buf_n     = '0;
            digit_count_n = '0;
            idle_cnt_n    = '0;
            if (int'(fail_cnt) + 1 >= MAX_TRIES) begin
              state_n    = LOCKED;
              locked_n   = 1'b1;
              fail_cnt_n = '0;
            end else begin
              state_n    = COLLECT;
              fail_cnt_n = fail_cnt + FW'(1);
            end
          end
        end
        GRANTED: ;
        LOCKED: begin
          if (unlock) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry.sv
// Bench for pin_entry: table of PIN attempts checked through a pin_done scoreboard, plus hand sequences for corner cases.
`timescale 1ns/1ps
module tb_pin_entry;
  localparam int PD = 4;
  localparam int MT = 3;
  localparam int TO = 20;

  logic        clk = 1'b0, rst = 1'b0, card_in = 1'b0, digit_valid = 1'b0;
  logic        clear = 1'b0, enter = 1'b0, unlock = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic [15:0] pin_expected = 16'h1234;
  logic [2:0]  digit_count;
  logic        pin_done, wrong_psw, pin_ok, locked, digit_err, pin_timeout;

  pin_entry #(.PIN_DIGITS(PD), .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .enter(enter), .unlock(unlock), .pin_expected(pin_expected),
    .digit_count(digit_count), .pin_done(pin_done), .wrong_psw(wrong_psw), .pin_ok(pin_ok),
    .locked(locked), .digit_err(digit_err), .pin_timeout(pin_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic wrong; logic lck; logic ok; } exp_t;
  typedef struct { logic rm; logic [15:0] keys; logic wrong; logic lck; logic ok; } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_chk = 0, n_fail = 0, cyc = 0, err_cnt = 0, to_cnt = 0, to_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] keys);
    for (int i = 0; i < PD; i++) key(keys[15-4*i -: 4]);
  endtask

  task automatic press_enter();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  // Pulse monitors and pin_done scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (digit_err) err_cnt++;
    if (pin_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (pin_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_pin_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("pin_done_cycle", cyc, e.due);
        chk("wrong_psw", wrong_psw, e.wrong);
        chk("locked", locked, e.lck);
        chk("pin_ok", pin_ok, e.ok);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, a, t0;
    //          rm    keys      wrong lck  ok
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 16'h1235, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h1235, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h1235, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h1111, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h1234, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 16'h9999, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h1230, 1'b1, 1'b1, 1'b0};

    #2;
    chk("rst_outputs", {digit_count, pin_done, wrong_psw, pin_ok, locked, digit_err, pin_timeout}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rm) begin
        card_in = 1'b0;
        step();
        chk("removed_pin_ok", pin_ok, 0);
        chk("removed_wrong_psw", wrong_psw, 0);
        card_in = 1'b1;
        step();
      end else begin
        chk("wrong_psw_held", wrong_psw, vecs[v-1].wrong);
      end
      enter_pin(vecs[v].keys);
      chk("count_full", digit_count, 4);
      press_enter();
      sb.push_back('{cyc + 1, vecs[v].wrong, vecs[v].lck, vecs[v].ok});
      repeat (3) step();
      if (!vecs[v].ok) chk("count_cleared_on_miss", digit_count, 0);
    end

    // Locked: keypad ignored, survives reinsertion, unlock releases
    e0 = err_cnt;
    key(4'd1);
    key(4'd2);
    clear = 1'b1; step(); clear = 1'b0;
    press_enter();
    step();
    chk("locked_held", locked, 1);
    chk("locked_count", digit_count, 0);
    chk("locked_no_err", err_cnt, e0);
    card_in = 1'b0; step(); card_in = 1'b1; step(); step();
    chk("locked_after_reinsert", locked, 1);
    enter_pin(16'h1234);
    press_enter();
    repeat (3) step();
    chk("locked_keys_ignored", digit_count, 0);
    unlock = 1'b1; step(); unlock = 1'b0;
    chk("unlocked", locked, 0);
    step();
    key(4'd5);
    chk("collect_after_unlock", digit_count, 1);

    // Rejected keys, premature enter and priority rules
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_count", digit_count, 0);
    e0 = err_cnt;
    key(4'd1);
    key(4'd2);
    key(4'hA);
    press_enter();
    step();
    chk("bad_key_enter_errs", err_cnt, e0 + 2);
    chk("bad_key_count", digit_count, 2);
    digit = 4'd7; digit_valid = 1'b1; enter = 1'b1;
    step();
    digit_valid = 1'b0; enter = 1'b0;
    step();
    chk("enter_beats_digit_count", digit_count, 2);
    chk("enter_beats_digit_err", err_cnt, e0 + 3);
    key(4'd3);
    key(4'd4);
    key(4'd5);
    step();
    chk("fifth_key_err", err_cnt, e0 + 4);
    chk("fifth_key_count", digit_count, 4);
    digit = 4'd1; digit_valid = 1'b1; enter = 1'b1; clear = 1'b1;
    step();
    digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
    repeat (3) step();
    chk("clear_wins_count", digit_count, 0);
    chk("clear_wins_no_err", err_cnt, e0 + 4);

    // Inactivity timeout
    key(4'd1);
    key(4'd2);
    a  = cyc;
    t0 = to_cnt;
    repeat (TO + 5) step();
    chk("timeout_pulses", to_cnt, t0 + 1);
    chk("timeout_cycle", to_cyc, a + TO);
    chk("timeout_count", digit_count, 0);
    card_in = 1'b0;
    step();

    // Reset mid-entry and mid-check
    card_in = 1'b1;
    step(); step();
    key(4'd1); key(4'd2); key(4'd3);
    chk("pre_reset_count", digit_count, 3);
    rst = 1'b0;
    #1;
    chk("reset_count_immediate", digit_count, 0);
    step();
    rst = 1'b1;
    step();
    enter_pin(16'h1234);
    press_enter();
    rst = 1'b0;
    #1;
    chk("reset_in_check_outputs", {digit_count, pin_ok, locked}, 0);
    step();
    rst = 1'b1;
    repeat (4) step();
    card_in = 1'b0;
    step();

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_entry.md
PIN_ENTRY -- requirements
Module: pin_entry

Interface
REQ-001 Parameter PIN_DIGITS, default 4, number of decimal digits in a PIN.
REQ-002 Parameter MAX_TRIES, default 3, consecutive mismatches before lockout.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, inactivity limit while collecting digits.
REQ-004 Port clk input 1 rising-edge clock; one clock domain.
REQ-005 Port rst input 1 reset, asynchronous and active-low.
REQ-006 Port card_in input 1 card present level.
REQ-007 Port digit_valid input 1 keypad strobe, one cycle per key press.
REQ-008 Port digit input 4 BCD key value, sampled when digit_valid=1.
REQ-009 Port clear input 1 erase all entered digits.
REQ-010 Port enter input 1 submit entered PIN.
REQ-011 Port unlock input 1 operator pulse that clears lockout.
REQ-012 Port pin_expected input 4*PIN_DIGITS stored PIN for inserted card, first digit in MS nibble, stable while card_in=1.
REQ-013 Port digit_count output 3 digits currently held.
REQ-014 Port pin_done output 1 one-cycle pulse, comparison result valid.
REQ-015 Port wrong_psw output 1 mismatch flag, updated with pin_done.
REQ-016 Port pin_ok output 1 level, PIN accepted for current card.
REQ-017 Port locked output 1 level, lockout active.
REQ-018 Port digit_err output 1 one-cycle pulse, rejected key or premature enter.
REQ-019 Port pin_timeout output 1 one-cycle pulse, inactivity expiry.

Function
REQ-020 States SHALL be IDLE, COLLECT, CHECK, GRANTED, LOCKED; all outputs registered.
REQ-021 IDLE: card_in=1 and locked=0 -> COLLECT with buffer=0, digit_count=0, idle counter=0; card_in=1 and locked=1 -> LOCKED.
REQ-022 COLLECT: digit_valid with digit<=9 and digit_count<PIN_DIGITS -> buffer shifts left one nibble, digit enters LS nibble, digit_count+1.
REQ-023 COLLECT: digit_valid with digit>9, or with digit_count==PIN_DIGITS -> key ignored, digit_err pulses next cycle.
REQ-024 COLLECT: clear -> buffer=0, digit_count=0; clear wins over digit_valid and enter in the same cycle.
REQ-025 COLLECT: enter with digit_count==PIN_DIGITS -> CHECK; enter with fewer digits -> digit_err pulse, stay; enter wins over digit_valid in the same cycle.
REQ-026 COLLECT: idle counter SHALL reset on any digit_valid, clear or enter, else increment; reaching TIMEOUT_CYCLES-1 -> pin_timeout pulse, buffer cleared, go IDLE, fail count unchanged.
REQ-027 CHECK lasts exactly one cycle; pin_done=1 on the cycle after CHECK, i.e. 2 cycles after enter was sampled.
REQ-028 Match: wrong_psw=0, fail count=0, pin_ok=1, state GRANTED.
REQ-029 Mismatch with fail count+1<MAX_TRIES: wrong_psw=1, fail count+1, buffer and digit_count cleared, state COLLECT.
REQ-030 Mismatch with fail count+1==MAX_TRIES: wrong_psw=1, locked=1, fail count=0, state LOCKED, same cycle as pin_done.
REQ-031 wrong_psw SHALL hold its value until the next pin_done or a return to IDLE (cleared to 0).
REQ-032 GRANTED: pin_ok=1 held; digit_valid, clear, enter ignored with no digit_err.
REQ-033 LOCKED: all keypad inputs ignored; unlock -> locked=0, state IDLE.
REQ-034 card_in=0 in any non-IDLE state -> IDLE next cycle, buffer, digit_count, pin_ok, wrong_psw, fail count cleared; locked unchanged; takes priority over all other inputs.
REQ-035 unlock in a state other than LOCKED SHALL only clear locked.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE, buffer=0, fail count=0, idle counter=0, and all outputs 0, including locked.
REQ-037 Reset asserted mid-entry or mid-CHECK SHALL discard the attempt with no pin_done.

Verification
REQ-038 pin_expected=0x1234, card_in=1, keys 1,2,3,4, enter -> pin_done and wrong_psw=0 2 cycles after enter, pin_ok=1.
REQ-039 Keys 1,2,3,5 + enter three times (PIN 0x1234) -> wrong_psw=1 each; locked=1 with third pin_done; card_in=1 keeps LOCKED; unlock -> IDLE.
REQ-040 Keys 1,2, key 0xA, enter -> two digit_err pulses, digit_count=2; clear -> digit_count=0.
REQ-041 Keys 1,2 then no activity for TIMEOUT_CYCLES -> single pin_timeout pulse, digit_count=0, state IDLE.
REQ-042 Two wrong attempts, card_in=0, reinsert, one wrong attempt -> locked=0 (fail count cleared on removal).
REQ-043 rst=0 for one cycle after keys 1,2,3 -> digit_count=0 immediately; no pin_done thereafter.
